// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: conditions raw MISO/SCLK/CS and sequences an external 8-bit
// shift register through address, write-data or read phases of an SPI transfer.
module spi_master_ctrl #(
   parameter int WIDTH       = 8,
   parameter int CNT_W       = 3,
   parameter int WAIT_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             miso_raw,
   input  logic             sclk_raw,
   input  logic             cs_raw,
   input  logic [WIDTH-1:0] addr_in,
   input  logic [WIDTH-1:0] data_in,
   input  logic             sr_sout,
   output logic             miso_cond,
   output logic             sclk_pos,
   output logic             sclk_neg,
   output logic             cs_cond,
   output logic [1:0]       sr_mode,
   output logic [WIDTH-1:0] sr_pin,
   output logic             mux_sel,
   output logic             addr_fe,
   output logic             data_fe,
   output logic             in_fe,
   output logic             mosi_buf
);
   typedef enum logic [3:0] {IDLE, CAPT, LDA, SHA, LDD, SHD, SHR, RDY, DONE} state_t;
   localparam logic [2:0] RST_VAL = 3'b100;
   logic [2:0]       raw, s1, s2, cond, upd;
   logic [CNT_W-1:0] cnt [3];
   logic             cs_fall;
   state_t           st, nxt;
   logic [WIDTH-1:0] addr_q, data_q;
   logic [3:0]       bcnt;
   logic             rw;
   assign raw       = {cs_raw, sclk_raw, miso_raw};
   assign miso_cond = cond[0];
   assign cs_cond   = cond[2];
   assign sr_pin    = mux_sel ? addr_q : data_q;
   // a conditioned bit only follows its synchronised input after WAIT_CYCLES+1 stable cycles
   always_comb begin
      for (int i = 0; i < 3; i++)
         upd[i] = (s2[i] != cond[i]) && (cnt[i] == CNT_W'(WAIT_CYCLES));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= RST_VAL;
         s2       <= RST_VAL;
         cond     <= RST_VAL;
         sclk_pos <= 1'b0;
         sclk_neg <= 1'b0;
         cs_fall  <= 1'b0;
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         s1       <= raw;
         s2       <= s1;
         sclk_pos <= upd[1] && s2[1];
         sclk_neg <= upd[1] && !s2[1];
         cs_fall  <= upd[2] && !s2[2];
         for (int i = 0; i < 3; i++) begin
            cnt[i] <= (s2[i] == cond[i] || upd[i]) ? '0 : cnt[i] + 1'b1;
            if (upd[i]) cond[i] <= s2[i];
         end
      end
   end
   always_comb begin
      nxt      = st;
      sr_mode  = 2'b00;
      mux_sel  = 1'b1;
      addr_fe  = 1'b0;
      data_fe  = 1'b0;
      in_fe    = 1'b0;
      mosi_buf = 1'b0;
      case (st)
         IDLE: nxt = cs_fall ? CAPT : IDLE;
         CAPT: begin
            addr_fe = 1'b1;
            data_fe = 1'b1;
            nxt     = LDA;
         end
         LDA: begin
            sr_mode = 2'b10;
            nxt     = SHA;
         end
         SHA: begin
            mosi_buf = 1'b1;
            sr_mode  = sclk_pos ? 2'b01 : 2'b00;
            if (sclk_pos && bcnt == 4'd7) nxt = rw ? SHR : LDD;
         end
         LDD: begin
            mux_sel = 1'b0;
            sr_mode = 2'b10;
            nxt     = SHD;
         end
         SHD: begin
            mosi_buf = 1'b1;
            sr_mode  = sclk_pos ? 2'b01 : 2'b00;
            if (sclk_pos && bcnt == 4'd7) nxt = DONE;
         end
         SHR: begin
            sr_mode = sclk_pos ? 2'b01 : 2'b00;
            if (sclk_pos && bcnt == 4'd7) nxt = RDY;
         end
         RDY: begin
            in_fe = 1'b1;
            nxt   = DONE;
         end
         DONE: nxt = DONE;
         default: nxt = IDLE;
      endcase
      // CS released mid-transfer: drop every command and strobe, return to IDLE
      if (st != IDLE && cs_cond) begin
         nxt      = IDLE;
         sr_mode  = 2'b00;
         mux_sel  = 1'b1;
         addr_fe  = 1'b0;
         data_fe  = 1'b0;
         in_fe    = 1'b0;
         mosi_buf = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st     <= IDLE;
         addr_q <= '0;
         data_q <= '0;
         bcnt   <= '0;
         rw     <= 1'b0;
      end else begin
         st <= nxt;
         if (st == CAPT) begin
            addr_q <= addr_in;
            data_q <= data_in;
         end
         bcnt <= (nxt != st) ? 4'd0 : (sr_mode == 2'b01) ? bcnt + 4'd1 : bcnt;
         if (st == SHA && sclk_pos && bcnt == 4'd0) rw <= sr_sout;
      end
   end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: randomized transactions against a transaction-level model
// of the expected loads, shifts, MOSI enables and strobes.
module tb_spi_master_ctrl;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       miso_raw = 1'b0, sclk_raw = 1'b0, cs_raw = 1'b1;
   logic [7:0] addr_in = '0, data_in = '0;
   logic       sr_sout;
   logic       miso_cond, sclk_pos, sclk_neg, cs_cond, mux_sel;
   logic       addr_fe, data_fe, in_fe, mosi_buf;
   logic [1:0] sr_mode;
   logic [7:0] sr_pin;
   logic [7:0] sreg = '0;
   int n_chk = 0, n_pass = 0;
   bit mon = 1'b0;
   logic [7:0] loads[$];
   bit mosi_q[$];
   int n_afe, n_dfe, n_infe, n_pos, n_neg;

   spi_master_ctrl dut (
      .clk(clk), .rst_n(rst_n), .miso_raw(miso_raw), .sclk_raw(sclk_raw),
      .cs_raw(cs_raw), .addr_in(addr_in), .data_in(data_in), .sr_sout(sr_sout),
      .miso_cond(miso_cond), .sclk_pos(sclk_pos), .sclk_neg(sclk_neg),
      .cs_cond(cs_cond), .sr_mode(sr_mode), .sr_pin(sr_pin), .mux_sel(mux_sel),
      .addr_fe(addr_fe), .data_fe(data_fe), .in_fe(in_fe), .mosi_buf(mosi_buf)
   );

   always #5 clk = ~clk;
   assign sr_sout = sreg[7];
   // external shift register
   always @(posedge clk)
      if (sr_mode == 2'b10) sreg <= sr_pin;
      else if (sr_mode == 2'b01) sreg <= {sreg[6:0], 1'b0};

   always @(negedge clk)
      if (mon) begin
         if (sr_mode == 2'b10) loads.push_back(sr_pin);
         if (sr_mode == 2'b01) mosi_q.push_back(mosi_buf);
         n_afe  += int'(addr_fe);
         n_dfe  += int'(data_fe);
         n_infe += int'(in_fe);
         n_pos  += int'(sclk_pos);
         n_neg  += int'(sclk_neg);
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_mon();
      loads.delete();
      mosi_q.delete();
      n_afe = 0; n_dfe = 0; n_infe = 0; n_pos = 0; n_neg = 0;
   endtask

   task automatic pulses(input int n);
      repeat (n) begin
         sclk_raw = 1'b1; cyc(8);
         sclk_raw = 1'b0; cyc(8);
      end
   endtask

   task automatic idle_outs(input string tag);
      chk({tag, ".cs_cond"}, 32'(cs_cond), 1);
      chk({tag, ".sr_mode"}, 32'(sr_mode), 0);
      chk({tag, ".mux_sel"}, 32'(mux_sel), 1);
      chk({tag, ".mosi_buf"}, 32'(mosi_buf), 0);
      chk({tag, ".strobes"}, 32'({addr_fe, data_fe, in_fe, sclk_pos, sclk_neg}), 0);
   endtask

   task automatic txn(input logic [7:0] a, input logic [7:0] d, input int nclk, input string tag);
      logic [7:0] e[$];
      bit rw;
      rw = a[7];
      e.push_back(a);
      if (nclk >= 8 && !rw) e.push_back(d);
      clr_mon();
      mon = 1'b1;
      addr_in = a; data_in = d; cs_raw = 1'b0;
      cyc(14);
      pulses(nclk);
      cyc(6);
      cs_raw = 1'b1;
      cyc(12);
      mon = 1'b0;
      chk({tag, ".nloads"}, 32'(loads.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < loads.size(); i++)
         chk($sformatf("%s.load%0d", tag, i), 32'(loads[i]), 32'(e[i]));
      chk({tag, ".nshift"}, 32'(mosi_q.size()), 32'(nclk));
      for (int i = 0; i < mosi_q.size(); i++)
         chk($sformatf("%s.mosi%0d", tag, i), 32'(mosi_q[i]), 32'(i < 8 || !rw));
      chk({tag, ".in_fe"}, 32'(n_infe), 32'(rw && nclk >= 16));
      chk({tag, ".addr_fe"}, 32'(n_afe), 1);
      chk({tag, ".data_fe"}, 32'(n_dfe), 1);
      idle_outs(tag);
   endtask

   initial begin
      cyc(3);
      idle_outs("reset");
      chk("reset.sr_pin", 32'(sr_pin), 0);
      chk("reset.miso", 32'(miso_cond), 0);
      rst_n = 1'b1;
      cyc(10);
      idle_outs("post_reset");
      // glitch and clean pulse on SCLK while idle
      clr_mon(); mon = 1'b1;
      sclk_raw = 1'b1; cyc(2); sclk_raw = 1'b0; cyc(12);
      chk("glitch.pos", 32'(n_pos), 0);
      chk("glitch.neg", 32'(n_neg), 0);
      pulses(1);
      chk("clean.pos", 32'(n_pos), 1);
      chk("clean.neg", 32'(n_neg), 1);
      chk("idle_sclk.shift", 32'(mosi_q.size()), 0);
      mon = 1'b0;
      // MISO step latency
      begin
         int n;
         miso_raw = 1'b1;
         n = 0;
         while (n < 20 && !miso_cond) begin cyc(1); n++; end
         chk("miso.rise_lat", 32'(n), 6);
         miso_raw = 1'b0;
         n = 0;
         while (n < 20 && miso_cond) begin cyc(1); n++; end
         chk("miso.fall_lat", 32'(n), 6);
      end
      txn(8'h25, 8'hA5, 16, "write");
      txn(8'h91, 8'h3C, 16, "read");
      txn(8'h25, 8'hA5, 4, "abort");
      clr_mon(); mon = 1'b1;
      pulses(2);
      mon = 1'b0;
      chk("after_abort.shift", 32'(mosi_q.size()), 0);
      chk("after_abort.loads", 32'(loads.size()), 0);
      for (int k = 0; k < 6; k++)
         txn(8'($urandom), 8'($urandom), 16, $sformatf("rnd%0d", k));
      txn(8'($urandom), 8'($urandom), int'($urandom_range(1, 15)), "rnd_abort");
      // reset asserted in the middle of the data phase
      addr_in = 8'h25; data_in = 8'hA5; cs_raw = 1'b0;
      cyc(14);
      pulses(12);
      chk("mid_shd.mosi", 32'(mosi_buf), 1);
      chk("mid_shd.cs", 32'(cs_cond), 0);
      #2 rst_n = 1'b0;
      #1;
      idle_outs("rst_mid");
      chk("rst_mid.sr_pin", 32'(sr_pin), 0);
      cs_raw = 1'b1;
      cyc(2);
      rst_n = 1'b1;
      cyc(10);
      idle_outs("after_rst");
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
